// File: rtl/led_pkg.sv
// Shared defaults and types for the LED fade/PWM stage.
package led_pkg;

   localparam int unsigned LED_N_CH      = 4;
   localparam int unsigned LED_PWM_BITS  = 8;
   localparam int unsigned LED_FADE_DIV  = 24000;
   localparam int unsigned LED_FADE_STEP = 16;

   typedef logic [LED_PWM_BITS-1:0] level_t;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: brightness level with saturating fade, period-aligned duty
// shadow register, and the registered PWM compare.
module led_pwm_channel
   import led_pkg::*;
#(
   parameter int unsigned PWM_BITS  = LED_PWM_BITS,
   parameter int unsigned FADE_STEP = LED_FADE_STEP
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                set,
   input  logic                fade_tick,
   input  logic                load,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   output logic                led
);

   localparam logic [PWM_BITS-1:0] MAX  = '1;
   localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(FADE_STEP);

   logic [PWM_BITS-1:0] level;
   logic [PWM_BITS-1:0] duty;
   logic [PWM_BITS-1:0] level_dec;

   always_comb begin
      level_dec = '0;
      if (level > STEP) level_dec = level - STEP;
   end

   // duty only follows level at the end of a period, so a period never glitches
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level <= '0;
         duty  <= '0;
         led   <= 1'b0;
      end else if (clr) begin
         level <= '0;
         duty  <= '0;
         led   <= 1'b0;
      end else begin
         if (set)            level <= MAX;
         else if (fade_tick) level <= level_dec;
         if (load) duty <= level;
         led <= (duty == MAX) ? 1'b1 : (pwm_cnt < duty);
      end
   end

endmodule

// File: rtl/led_fade_pwm.sv
// LED pattern to PWM drive with comet-tail fade; owns the shared PWM and fade
// timebases and fans them out to one led_pwm_channel per LED.
module led_fade_pwm
   import led_pkg::*;
#(
   parameter int unsigned N_CH      = LED_N_CH,
   parameter int unsigned PWM_BITS  = LED_PWM_BITS,
   parameter int unsigned FADE_DIV  = LED_FADE_DIV,
   parameter int unsigned FADE_STEP = LED_FADE_STEP
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            enable,
   input  logic [N_CH-1:0] pattern_in,
   output logic [N_CH-1:0] led_out,
   output logic            pwm_wrap
);

   localparam int unsigned         FADE_W    = $clog2(FADE_DIV);
   localparam logic [FADE_W-1:0]   FADE_LAST = FADE_W'(FADE_DIV - 1);
   localparam logic [PWM_BITS-1:0] PWM_MAX   = '1;

   logic [PWM_BITS-1:0] pwm_cnt;
   logic [FADE_W-1:0]   fade_cnt;
   logic                fade_tick;
   logic                load;
   logic                clr;

   always_comb begin
      fade_tick = (fade_cnt == FADE_LAST);
      load      = (pwm_cnt == PWM_MAX);
      clr       = ~enable;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt  <= '0;
         fade_cnt <= '0;
         pwm_wrap <= 1'b0;
      end else if (!enable) begin
         pwm_cnt  <= '0;
         fade_cnt <= '0;
         pwm_wrap <= 1'b0;
      end else begin
         pwm_cnt  <= pwm_cnt + 1'b1;
         fade_cnt <= fade_tick ? '0 : fade_cnt + 1'b1;
         pwm_wrap <= (pwm_cnt == '0);
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      led_pwm_channel #(
         .PWM_BITS  (PWM_BITS),
         .FADE_STEP (FADE_STEP)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .clr       (clr),
         .set       (pattern_in[i]),
         .fade_tick (fade_tick),
         .load      (load),
         .pwm_cnt   (pwm_cnt),
         .led       (led_out[i])
      );
   end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Bench for led_fade_pwm with PWM_BITS=4, FADE_DIV=4, FADE_STEP=4: per-cycle
// scoreboard against a behavioural model plus hand-derived per-period counts.
module tb_led_fade_pwm;

   localparam logic [3:0] MAX = 4'hF;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic [3:0] pattern_in = 4'b0000;
   logic [3:0] led_out;
   logic       pwm_wrap;

   always #5 clk = ~clk;

   led_fade_pwm #(
      .N_CH      (4),
      .PWM_BITS  (4),
      .FADE_DIV  (4),
      .FADE_STEP (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .pattern_in (pattern_in),
      .led_out    (led_out),
      .pwm_wrap   (pwm_wrap)
   );

   typedef struct packed {
      logic [3:0] led;
      logic       wrap;
   } exp_t;

   typedef struct {
      logic [3:0]      pat;
      logic [3:0]      pulse;  // extra bits driven only on step 12 of the window
      logic [3:0][4:0] hi;     // expected high count per channel, {ch3,ch2,ch1,ch0}
   } win_t;

   exp_t        sb[$];
   win_t        tbl[15];
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   logic [3:0]  m_pwm;
   int unsigned m_fade;
   logic [3:0]  m_level[4];
   logic [3:0]  m_duty[4];
   logic [3:0]  m_led;
   logic        m_wrap;

   int unsigned kcnt;
   int unsigned first_hi;
   int unsigned hi_cnt[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic model_clear();
      m_pwm  = '0;
      m_fade = 0;
      m_led  = '0;
      m_wrap = 1'b0;
      for (int i = 0; i < 4; i++) begin
         m_level[i] = '0;
         m_duty[i]  = '0;
      end
   endtask

   task automatic model_edge(input logic en, input logic [3:0] pat);
      logic tick;
      logic load;
      if (!rst_n || !en) begin
         model_clear();
      end else begin
         tick = (m_fade == 3);
         load = (m_pwm == MAX);
         m_wrap = (m_pwm == 4'd0);
         for (int i = 0; i < 4; i++) begin
            m_led[i] = (m_duty[i] == MAX) || (m_pwm < m_duty[i]);
            if (load) m_duty[i] = m_level[i];
            if (pat[i])    m_level[i] = MAX;
            else if (tick) m_level[i] = (m_level[i] > 4'd4) ? m_level[i] - 4'd4 : 4'd0;
         end
         m_pwm  = m_pwm + 4'd1;
         m_fade = (m_fade == 3) ? 0 : m_fade + 1;
      end
   endtask

   task automatic step(input logic en, input logic [3:0] pat);
      exp_t e;
      enable     = en;
      pattern_in = pat;
      model_edge(en, pat);
      e.led  = m_led;
      e.wrap = m_wrap;
      sb.push_back(e);
      @(posedge clk);
      #1;
      kcnt++;
      e = sb.pop_front();
      check("led_out", 32'(led_out), 32'(e.led));
      check("pwm_wrap", 32'(pwm_wrap), 32'(e.wrap));
      for (int i = 0; i < 4; i++) if (led_out[i]) hi_cnt[i]++;
      if (led_out[0] && first_hi == 0) first_hi = kcnt;
   endtask

   task automatic clear_hi();
      for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
   endtask

   initial begin
      #100000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      // Windows are 16-clk periods aligned to the first edge after reset release.
      tbl[0]  = '{4'b0001, 4'b0000, {5'd0,  5'd0,  5'd0,  5'd0 }};
      tbl[1]  = '{4'b0001, 4'b0000, {5'd0,  5'd0,  5'd0,  5'd16}};
      tbl[2]  = '{4'b0001, 4'b0000, {5'd0,  5'd0,  5'd0,  5'd16}};
      tbl[3]  = '{4'b0000, 4'b0000, {5'd0,  5'd0,  5'd0,  5'd16}};
      tbl[4]  = '{4'b0000, 4'b0000, {5'd0,  5'd0,  5'd0,  5'd3 }};
      tbl[5]  = '{4'b0010, 4'b0000, {5'd0,  5'd0,  5'd0,  5'd0 }};
      tbl[6]  = '{4'b0000, 4'b0000, {5'd0,  5'd0,  5'd16, 5'd0 }};
      tbl[7]  = '{4'b0000, 4'b0000, {5'd0,  5'd0,  5'd3,  5'd0 }};
      tbl[8]  = '{4'b1100, 4'b0000, {5'd0,  5'd0,  5'd0,  5'd0 }};
      tbl[9]  = '{4'b1000, 4'b0000, {5'd16, 5'd16, 5'd0,  5'd0 }};
      tbl[10] = '{4'b0000, 4'b0000, {5'd16, 5'd3,  5'd0,  5'd0 }};
      tbl[11] = '{4'b0000, 4'b0000, {5'd3,  5'd0,  5'd0,  5'd0 }};
      tbl[12] = '{4'b0000, 4'b0010, {5'd0,  5'd0,  5'd0,  5'd0 }};
      tbl[13] = '{4'b0000, 4'b0000, {5'd0,  5'd0,  5'd16, 5'd0 }};
      tbl[14] = '{4'b0001, 4'b0000, {5'd0,  5'd0,  5'd0,  5'd0 }};

      model_clear();
      kcnt     = 0;
      first_hi = 0;
      clear_hi();

      // reset held with enable and all pattern bits high
      repeat (3) step(1'b1, 4'b1111);
      check("reset_led", 32'(led_out), 32'h0);
      check("reset_wrap", 32'(pwm_wrap), 32'h0);

      rst_n    = 1'b1;
      kcnt     = 0;
      first_hi = 0;

      for (int p = 0; p < 15; p++) begin
         clear_hi();
         for (int j = 1; j <= 16; j++)
            step(1'b1, tbl[p].pat | ((j == 12) ? tbl[p].pulse : 4'b0000));
         for (int c = 0; c < 4; c++)
            check($sformatf("win%0d_hi_ch%0d", p, c), 32'(hi_cnt[c]), 32'(tbl[p].hi[c]));
      end
      check("first_on_within_18", 32'(first_hi >= 1 && first_hi <= 18), 32'h1);

      // asynchronous reset while channel 0 is solidly on
      repeat (5) step(1'b1, 4'b0001);
      check("pre_reset_led0", 32'(led_out[0]), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_led", 32'(led_out), 32'h0);
      check("async_reset_wrap", 32'(pwm_wrap), 32'h0);
      model_clear();
      repeat (2) step(1'b1, 4'b0001);
      rst_n = 1'b1;

      // one-cycle enable drop in the middle of a fade
      repeat (32) step(1'b1, 4'b0001);
      repeat (6) step(1'b1, 4'b0000);
      step(1'b0, 4'b0000);
      check("disable_led", 32'(led_out), 32'h0);
      check("disable_wrap", 32'(pwm_wrap), 32'h0);
      step(1'b1, 4'b0000);
      check("reenable_wrap", 32'(pwm_wrap), 32'h1);
      clear_hi();
      repeat (40) step(1'b1, 4'b0000);
      check("after_clear_hi", 32'(hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3]), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
